// File: rtl/sr_reg_pkg.sv
// Shared types for the PIM controller register bank: command codes and
// the sequencing states used while a multi-cycle rotate is in progress.
package sr_reg_pkg;

   typedef enum logic [1:0] {
      OP_LOAD  = 2'd0,
      OP_SHIFT = 2'd1,
      OP_ROT   = 2'd2,
      OP_CLR   = 2'd3
   } op_e;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_ROTATE = 1'b1
   } state_e;

endpackage

// File: rtl/sr_reg_entry.sv
// One WIDTH-bit bank entry: async active-low clear, synchronous clear,
// and load-enable with hold. The next-value mux lives in the bank top.
module sr_reg_entry #(
   parameter int WIDTH = 10
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr_i,
   input  logic             en_i,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] q_d;
   logic [WIDTH-1:0] q_q;

   // NOTE: the default-first assignment keeps this block purely combinational (no latch).
   always_comb begin
      q_d = q_q;
      if (clr_i) begin
         q_d = '0;
      end else if (en_i) begin
         q_d = d_i;
      end
   end

   // NOTE: state updates use <= so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q_q <= '0;
      end else begin
         q_q <= q_d;
      end
   end

   assign q_o = q_q;

endmodule

// File: rtl/sr_reg_bank.sv
// Addressable bank of DEPTH load-enabled registers with addressed load,
// shift-in/shift-out, multi-cycle rotate, clear and a registered read port.
module sr_reg_bank
   import sr_reg_pkg::*;
#(
   parameter int WIDTH  = 10,
   parameter int DEPTH  = 8,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              op_valid,
   output logic              op_ready,
   input  op_e               op_code,
   input  logic [ADDR_W-1:0] op_addr,
   input  logic [WIDTH-1:0]  op_data,
   output logic              op_done,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [WIDTH-1:0]  rd_data,
   output logic [WIDTH-1:0]  shift_out,
   output logic              shift_out_valid
);

   state_e              state_d, state_q;
   logic [ADDR_W-1:0]   cnt_d, cnt_q;
   logic                op_done_d, op_done_q;
   logic [WIDTH-1:0]    rd_data_d, rd_data_q;
   logic [WIDTH-1:0]    shift_out_d, shift_out_q;
   logic                shift_out_valid_d, shift_out_valid_q;

   logic [DEPTH-1:0][WIDTH-1:0] ent_q;
   logic [DEPTH-1:0][WIDTH-1:0] ent_d;
   logic [DEPTH-1:0]            ent_en;
   logic                        ent_clr;
   logic [ADDR_W-1:0]           rot_amt;

   assign rot_amt  = op_data[ADDR_W-1:0];
   assign op_ready = (state_q == ST_IDLE);

   always_comb begin
      state_d           = state_q;
      cnt_d             = cnt_q;
      op_done_d         = 1'b0;
      shift_out_d       = shift_out_q;
      shift_out_valid_d = 1'b0;
      ent_d             = ent_q;
      ent_en            = '0;
      ent_clr           = 1'b0;
      // Read-before-write: the read port always sees the pre-edge contents.
      rd_data_d         = ent_q[rd_addr];

      unique case (state_q)
         ST_IDLE: begin
            if (op_valid) begin
               unique case (op_code)
                  OP_LOAD: begin
                     ent_d[op_addr]  = op_data;
                     ent_en[op_addr] = 1'b1;
                     op_done_d       = 1'b1;
                  end
                  OP_SHIFT: begin
                     for (int i = 1; i < DEPTH; i++) begin
                        ent_d[i] = ent_q[i-1];
                     end
                     ent_d[0]          = op_data;
                     ent_en            = '1;
                     shift_out_d       = ent_q[DEPTH-1];
                     shift_out_valid_d = 1'b1;
                     op_done_d         = 1'b1;
                  end
                  OP_ROT: begin
                     if (rot_amt == '0) begin
                        op_done_d = 1'b1;
                     end else begin
                        state_d = ST_ROTATE;
                        cnt_d   = rot_amt;
                     end
                  end
                  OP_CLR: begin
                     ent_clr   = 1'b1;
                     op_done_d = 1'b1;
                  end
                  default: ;
               endcase
            end
         end
         ST_ROTATE: begin
            for (int i = 1; i < DEPTH; i++) begin
               ent_d[i] = ent_q[i-1];
            end
            ent_d[0] = ent_q[DEPTH-1];
            ent_en   = '1;
            cnt_d    = cnt_q - ADDR_W'(1);
            if (cnt_q == ADDR_W'(1)) begin
               state_d   = ST_IDLE;
               op_done_d = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   for (genvar g = 0; g < DEPTH; g++) begin : g_ent
      sr_reg_entry #(.WIDTH(WIDTH)) u_ent (
         .clk   (clk),
         .rst_n (rst_n),
         .clr_i (ent_clr),
         .en_i  (ent_en[g]),
         .d_i   (ent_d[g]),
         .q_o   (ent_q[g])
      );
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q           <= ST_IDLE;
         cnt_q             <= '0;
         op_done_q         <= 1'b0;
         rd_data_q         <= '0;
         shift_out_q       <= '0;
         shift_out_valid_q <= 1'b0;
      end else begin
         state_q           <= state_d;
         cnt_q             <= cnt_d;
         op_done_q         <= op_done_d;
         rd_data_q         <= rd_data_d;
         shift_out_q       <= shift_out_d;
         shift_out_valid_q <= shift_out_valid_d;
      end
   end

   assign op_done         = op_done_q;
   assign rd_data         = rd_data_q;
   assign shift_out       = shift_out_q;
   assign shift_out_valid = shift_out_valid_q;

endmodule

// File: tb/tb_sr_reg_bank.sv
// Directed plus randomized bench for sr_reg_bank, checked against an
// array-based model of the bank's command rules.
module tb_sr_reg_bank;
   import sr_reg_pkg::*;

   localparam int WIDTH = 10;
   localparam int DEPTH = 8;
   localparam int AW    = 3;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             op_valid;
   logic             op_ready;
   op_e              op_code;
   logic [AW-1:0]    op_addr;
   logic [WIDTH-1:0] op_data;
   logic             op_done;
   logic [AW-1:0]    rd_addr;
   logic [WIDTH-1:0] rd_data;
   logic [WIDTH-1:0] shift_out;
   logic             shift_out_valid;

   int checks   = 0;
   int failures = 0;

   int m_ent[DEPTH];
   int m_rot_left;
   int exp_rd, exp_so;
   bit exp_done, exp_sov;

   sr_reg_bank dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .op_valid        (op_valid),
      .op_ready        (op_ready),
      .op_code         (op_code),
      .op_addr         (op_addr),
      .op_data         (op_data),
      .op_done         (op_done),
      .rd_addr         (rd_addr),
      .rd_data         (rd_data),
      .shift_out       (shift_out),
      .shift_out_valid (shift_out_valid)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < DEPTH; i++) m_ent[i] = 0;
      m_rot_left = 0;
      exp_so     = 0;
   endtask

   // Rotate the model by one place toward higher indices.
   task automatic model_rot1();
      int last;
      last = m_ent[DEPTH-1];
      for (int i = DEPTH-1; i > 0; i--) m_ent[i] = m_ent[i-1];
      m_ent[0] = last;
   endtask

   // Apply the currently driven inputs to the model, clock once, compare.
   task automatic tick();
      int k;
      exp_rd   = m_ent[rd_addr];
      exp_done = 1'b0;
      exp_sov  = 1'b0;
      if (m_rot_left > 0) begin
         model_rot1();
         m_rot_left--;
         if (m_rot_left == 0) exp_done = 1'b1;
      end else if (op_valid) begin
         case (op_code)
            OP_LOAD: begin
               m_ent[op_addr] = int'(op_data);
               exp_done = 1'b1;
            end
            OP_SHIFT: begin
               exp_so  = m_ent[DEPTH-1];
               for (int i = DEPTH-1; i > 0; i--) m_ent[i] = m_ent[i-1];
               m_ent[0] = int'(op_data);
               exp_sov  = 1'b1;
               exp_done = 1'b1;
            end
            OP_ROT: begin
               k = int'(op_data) % DEPTH;
               if (k == 0) exp_done = 1'b1;
               else m_rot_left = k;
            end
            default: begin
               for (int i = 0; i < DEPTH; i++) m_ent[i] = 0;
               exp_done = 1'b1;
            end
         endcase
      end
      @(posedge clk);
      #1;
      check("rd_data", 32'(rd_data), 32'(exp_rd));
      check("op_done", 32'(op_done), 32'(exp_done));
      check("shift_out", 32'(shift_out), 32'(exp_so));
      check("shift_out_valid", 32'(shift_out_valid), 32'(exp_sov));
      check("op_ready", 32'(op_ready), 32'(m_rot_left == 0));
   endtask

   task automatic drive(input bit v, input op_e c, input int a, input int d);
      op_valid = v;
      op_code  = c;
      op_addr  = AW'(a);
      op_data  = WIDTH'(d);
   endtask

   task automatic idle();
      drive(1'b0, OP_LOAD, 0, 0);
   endtask

   initial begin
      int lows, n;
      rst_n   = 1'b0;
      rd_addr = '0;
      idle();
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check("rst_rd_data", 32'(rd_data), 32'h0);
      check("rst_op_done", 32'(op_done), 32'h0);
      check("rst_shift_out", 32'(shift_out), 32'h0);
      check("rst_sov", 32'(shift_out_valid), 32'h0);
      rst_n = 1'b1;
      #1;
      check("rst_op_ready", 32'(op_ready), 32'h1);

      // LOAD 0x155 @3 while reading addr 3: old value first, new one next.
      rd_addr = 3'd3;
      drive(1'b1, OP_LOAD, 3, 10'h155);
      tick();
      check("load_old_rd", 32'(rd_data), 32'h0);
      check("load_done", 32'(op_done), 32'h1);
      idle();
      tick();
      check("load_new_rd", 32'(rd_data), 32'h155);
      check("load_done_once", 32'(op_done), 32'h0);

      // Shift 1..9: ninth shift displaces the first value.
      for (int v = 1; v <= 9; v++) begin
         drive(1'b1, OP_SHIFT, 0, v);
         tick();
      end
      check("shift9_out", 32'(shift_out), 32'h1);
      check("shift9_valid", 32'(shift_out_valid), 32'h1);
      idle();
      tick();
      check("shift_valid_pulse", 32'(shift_out_valid), 32'h0);
      check("shift_out_hold", 32'(shift_out), 32'h1);
      for (int i = 0; i < DEPTH; i++) begin
         rd_addr = AW'(i);
         tick();
         check("shift_entry", 32'(rd_data), 32'(9 - i));
      end

      // Load i into entry i, then rotate by 3.
      for (int i = 0; i < DEPTH; i++) begin
         drive(1'b1, OP_LOAD, i, i);
         tick();
      end
      drive(1'b1, OP_ROT, 0, 3);
      tick();
      idle();
      lows = (op_ready == 1'b0) ? 1 : 0;
      n = 0;
      while (op_ready !== 1'b1 && n < 20) begin
         tick();
         n++;
         if (op_ready == 1'b0) lows++;
      end
      check("rot3_ready_low_cycles", 32'(lows), 32'd3);
      check("rot3_done", 32'(op_done), 32'h1);
      tick();
      check("rot3_done_once", 32'(op_done), 32'h0);
      for (int i = 0; i < DEPTH; i++) begin
         rd_addr = AW'(i);
         tick();
         check("rot3_entry", 32'(rd_data), 32'((i + DEPTH - 3) % DEPTH));
      end

      // ROT 0: no stall, no change, done pulse.
      drive(1'b1, OP_ROT, 0, 0);
      tick();
      check("rot0_ready", 32'(op_ready), 32'h1);
      check("rot0_done", 32'(op_done), 32'h1);
      idle();
      for (int i = 0; i < DEPTH; i++) begin
         rd_addr = AW'(i);
         tick();
         check("rot0_entry", 32'(rd_data), 32'((i + DEPTH - 3) % DEPTH));
      end

      // ROT 5 interrupted by reset during its second cycle.
      drive(1'b1, OP_ROT, 0, 5);
      tick();
      idle();
      tick();
      check("rot5_busy", 32'(op_ready), 32'h0);
      rst_n = 1'b0;
      #2;
      check("midrst_rd_data", 32'(rd_data), 32'h0);
      check("midrst_shift_out", 32'(shift_out), 32'h0);
      check("midrst_op_done", 32'(op_done), 32'h0);
      check("midrst_ready", 32'(op_ready), 32'h1);
      rst_n = 1'b1;
      model_reset();
      for (int i = 0; i < DEPTH; i++) begin
         rd_addr = AW'(i);
         tick();
         check("midrst_no_done", 32'(op_done), 32'h0);
         check("midrst_entry", 32'(rd_data), 32'h0);
      end

      // Same-cycle LOAD/read at addr 5, then CLR.
      drive(1'b1, OP_LOAD, 5, 10'h2A5);
      tick();
      rd_addr = 3'd5;
      drive(1'b1, OP_LOAD, 5, 10'h3FF);
      tick();
      check("rw_old", 32'(rd_data), 32'h2A5);
      idle();
      tick();
      check("rw_new", 32'(rd_data), 32'h3FF);
      drive(1'b1, OP_CLR, 0, 0);
      tick();
      idle();
      tick();
      check("clr_read", 32'(rd_data), 32'h0);

      // Randomized traffic, commands held while the bank is busy.
      for (int t = 0; t < 400; t++) begin
         if (op_ready) begin
            drive($urandom_range(0, 9) < 8, op_e'($urandom_range(0, 3)),
                  int'($urandom_range(0, DEPTH-1)), int'($urandom_range(0, 1023)));
         end
         rd_addr = AW'($urandom_range(0, DEPTH-1));
         tick();
      end
      idle();
      for (int i = 0; i < DEPTH + 2; i++) begin
         rd_addr = AW'(i % DEPTH);
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
